// File: rtl/disc_frame_loader.sv
// disc_frame_loader
//   Collects a frame of N_ELEM signed Q8.8 samples from an upstream generator,
//   presents the frame to a discriminator as one packed vector, fires a start
//   pulse and then captures the discriminator's score and decision. The result
//   is held until a downstream consumer takes it.
//
// Ports
//   clk, rst       : clock; asynchronous active-high reset
//   s_valid/s_data/s_last/s_ready : sample stream in (valid/ready handshake)
//   flat_input     : packed frame, element i at [(i+1)*DW-1 -: DW]
//   disc_start     : one-cycle start pulse to the discriminator
//   disc_score/disc_decision/disc_done : discriminator result inputs
//   res_valid/res_score/res_decision/res_ready : captured result out
//   frame_count    : number of frames whose result was consumed (wraps)
//   err_len        : one-cycle pulse when a frame ends early on s_last
module disc_frame_loader #(
  parameter int N_ELEM = 256,
  parameter int DW     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [DW-1:0]        s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [DW*N_ELEM-1:0] flat_input,
  output logic                 disc_start,
  input  logic [DW-1:0]        disc_score,
  input  logic                 disc_decision,
  input  logic                 disc_done,
  output logic                 res_valid,
  output logic [DW-1:0]        res_score,
  output logic                 res_decision,
  input  logic                 res_ready,
  output logic [15:0]          frame_count,
  output logic                 err_len
);

  localparam int IW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_START  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  logic [1:0]    state_reg;
  logic [IW-1:0] idx_reg;
  logic          done_q_reg;
  logic          res_valid_reg;
  logic [DW-1:0] res_score_reg;
  logic          res_decision_reg;
  logic [15:0]   frame_count_reg;
  logic          err_len_reg;
  logic [DW-1:0] sample_reg [N_ELEM];

  logic xfer;
  logic last_idx;
  logic done_rise;

  // s_ready is forced low during reset so no sample is taken while the
  // state register is being cleared.
  assign s_ready   = (state_reg == ST_FILL) && !rst;
  assign xfer      = s_valid && s_ready;
  assign last_idx  = (idx_reg == IW'(N_ELEM - 1));
  // Only a fresh rising edge of done counts; a level left high from the
  // previous frame must drop before it can complete a new one.
  assign done_rise = disc_done && !done_q_reg;

  assign disc_start   = (state_reg == ST_START);
  assign res_valid    = res_valid_reg;
  assign res_score    = res_score_reg;
  assign res_decision = res_decision_reg;
  assign frame_count  = frame_count_reg;
  assign err_len      = err_len_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_FILL;
      idx_reg          <= '0;
      done_q_reg       <= 1'b0;
      res_valid_reg    <= 1'b0;
      res_score_reg    <= '0;
      res_decision_reg <= 1'b0;
      frame_count_reg  <= '0;
      err_len_reg      <= 1'b0;
    end else begin
      done_q_reg  <= disc_done;
      err_len_reg <= 1'b0;
      case (state_reg)
        ST_FILL: begin
          if (xfer) begin
            if (last_idx) begin
              // s_last on the final sample is harmless and ignored.
              idx_reg   <= '0;
              state_reg <= ST_START;
            end else if (s_last) begin
              // Short frame: keep the written sample, restart at element 0.
              idx_reg     <= '0;
              err_len_reg <= 1'b1;
            end else begin
              idx_reg <= idx_reg + IW'(1);
            end
          end
        end
        ST_START: state_reg <= ST_WAIT;
        ST_WAIT: begin
          if (done_rise) begin
            res_score_reg    <= disc_score;
            res_decision_reg <= disc_decision;
            res_valid_reg    <= 1'b1;
            state_reg        <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (res_valid_reg && res_ready) begin
            res_valid_reg   <= 1'b0;
            frame_count_reg <= frame_count_reg + 16'd1;
            idx_reg         <= '0;
            state_reg       <= ST_FILL;
          end
        end
        default: state_reg <= ST_FILL;
      endcase
    end
  end

  // Frame storage: one register per element so the whole frame is visible
  // in parallel. Writes only happen in FILL, which keeps flat_input stable
  // from START until the result is consumed.
  generate
    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sample_reg[gi] <= '0;
        end else if (xfer && (idx_reg == IW'(gi))) begin
          sample_reg[gi] <= s_data;
        end
      end
      assign flat_input[(gi+1)*DW-1 -: DW] = sample_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_disc_frame_loader.sv
// Directed testbench for disc_frame_loader: short frame, ramp frame with a
// delayed discriminator stub, held done level across frames, reset mid-WAIT.
module tb_disc_frame_loader;

  localparam int N  = 256;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic [DW*N-1:0] flat_input;
  logic          disc_start;
  logic [DW-1:0] disc_score;
  logic          disc_decision;
  logic          disc_done;
  logic          res_valid;
  logic [DW-1:0] res_score;
  logic          res_decision;
  logic          res_ready;
  logic [15:0]   frame_count;
  logic          err_len;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  disc_frame_loader #(.N_ELEM(N), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .flat_input(flat_input), .disc_start(disc_start),
    .disc_score(disc_score), .disc_decision(disc_decision), .disc_done(disc_done),
    .res_valid(res_valid), .res_score(res_score), .res_decision(res_decision),
    .res_ready(res_ready), .frame_count(frame_count), .err_len(err_len)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] elem(input int i);
    return flat_input[i*DW +: DW];
  endfunction

  // Called just after a negedge; drives n samples base+k, one per cycle.
  // Returns at the negedge following the last transfer. early_start counts
  // disc_start seen before the last transfer.
  task automatic send_frame(input int n, input logic [DW-1:0] base,
                            input bit last_on_end, output int early_start);
    early_start = 0;
    for (int k = 0; k < n; k++) begin
      if (disc_start) early_start++;
      s_valid = 1'b1;
      s_data  = base + DW'(k);
      s_last  = last_on_end && (k == n - 1);
      @(negedge clk);
    end
    s_last  = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  int es;
  int hold_ok;

  initial begin
    rst = 1'b1; s_valid = 0; s_data = 0; s_last = 0;
    disc_score = 0; disc_decision = 0; disc_done = 0; res_ready = 0;
    step(2);
    // Reset state
    check("rst_s_ready", s_ready, 0);
    check("rst_flat_zero", |flat_input, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_disc_start", disc_start, 0);
    check("rst_err_len", err_len, 0);
    rst = 1'b0;
    #1;
    check("rel_s_ready", s_ready, 1);
    step(1);

    // Short frame: s_last on 100th sample
    send_frame(100, 16'h1000, 1'b1, es);
    check("short_err_len_pulse", err_len, 1);
    check("short_no_start", disc_start, 0);
    check("short_early_start", es, 0);
    check("short_elem99", elem(99), 16'h1063);
    check("short_s_ready", s_ready, 1);
    step(1);
    check("short_err_len_clear", err_len, 0);
    check("short_no_start2", disc_start, 0);

    // Full ramp frame
    send_frame(N, 16'h0000, 1'b0, es);
    check("ramp_early_start", es, 0);
    check("ramp_start_pulse", disc_start, 1);
    check("ramp_s_ready_start", s_ready, 0);
    // Hold s_valid with junk through START/WAIT/RESULT
    s_valid = 1'b1; s_data = 16'hDEAD;
    step(1);
    check("ramp_start_one_cycle", disc_start, 0);
    check("ramp_e0", elem(0), 16'h0000);
    check("ramp_e1", elem(1), 16'h0001);
    check("ramp_e99", elem(99), 16'h0063);
    check("ramp_e100", elem(100), 16'h0064);
    check("ramp_e255", elem(255), 16'h00FF);
    step(8);
    check("wait_no_res", res_valid, 0);
    check("wait_s_ready", s_ready, 0);
    step(1);
    // Stub: done rises 10 cycles after the start pulse
    disc_done = 1'b1; disc_score = 16'h0180; disc_decision = 1'b1;
    step(1);
    check("res_valid", res_valid, 1);
    check("res_score", res_score, 16'h0180);
    check("res_decision", res_decision, 1);
    disc_score = 16'h7777; disc_decision = 1'b0;
    hold_ok = 0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (res_valid && res_score == 16'h0180 && res_decision && !s_ready) hold_ok++;
    end
    check("res_hold_5", hold_ok, 5);
    check("hold_flat_e0", elem(0), 16'h0000);
    check("hold_flat_e255", elem(255), 16'h00FF);
    s_valid = 1'b0;
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    check("ack_res_valid", res_valid, 0);
    check("ack_frame_count", frame_count, 1);
    check("ack_s_ready", s_ready, 1);

    // Frame 2 with disc_done still high from frame 1
    send_frame(N, 16'hA000, 1'b0, es);
    check("f2_start", disc_start, 1);
    check("f2_e5", elem(5), 16'hA005);
    step(6);
    check("f2_stale_done_ignored", res_valid, 0);
    disc_done = 1'b0;
    step(1);
    check("f2_no_res_low", res_valid, 0);
    disc_done = 1'b1; disc_score = 16'hFF00; disc_decision = 1'b0;
    step(1);
    check("f2_res_valid", res_valid, 1);
    check("f2_res_score", res_score, 16'hFF00);
    check("f2_res_decision", res_decision, 0);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0; disc_done = 1'b0;
    check("f2_frame_count", frame_count, 2);

    // Frame 3 aborted by reset in WAIT
    send_frame(N, 16'h5500, 1'b0, es);
    check("f3_start", disc_start, 1);
    step(3);
    rst = 1'b1;
    #1;
    check("r3_s_ready", s_ready, 0);
    check("r3_flat_zero", |flat_input, 0);
    check("r3_frame_count", frame_count, 0);
    check("r3_res_valid", res_valid, 0);
    check("r3_res_score", res_score, 0);
    check("r3_disc_start", disc_start, 0);
    step(2);
    rst = 1'b0;
    #1;
    check("r3_rel_s_ready", s_ready, 1);
    step(1);
    disc_done = 1'b1; disc_score = 16'h1234; disc_decision = 1'b1;
    step(4);
    check("r3_done_ignored", res_valid, 0);
    check("r3_still_fill", s_ready, 1);
    check("r3_no_start", disc_start, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/disc_frame_loader.md
DISC_FRAME_LOADER -- requirements
Module: disc_frame_loader

Interface
REQ-001 Parameter N_ELEM, 256, number of Q8.8 samples per frame.
REQ-002 Parameter DW, 16, sample width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s_valid  input  1  upstream (generator) sample valid.
REQ-006 s_data  input  DW  signed Q8.8 sample.
REQ-007 s_last  input  1  upstream end-of-frame marker, qualified by s_valid.
REQ-008 s_ready  output  1  loader accepts a sample this cycle.
REQ-009 flat_input  output  DW*N_ELEM  packed frame to discriminator; element i at bits [(i+1)*DW-1 -: DW].
REQ-010 disc_start  output  1  one-cycle start pulse to discriminator.
REQ-011 disc_score  input  DW  discriminator score_out, signed Q8.8.
REQ-012 disc_decision  input  1  discriminator decision_real.
REQ-013 disc_done  input  1  discriminator done (pulse or level).
REQ-014 res_valid  output  1  captured result available.
REQ-015 res_score  output  DW  captured score.
REQ-016 res_decision  output  1  captured decision.
REQ-017 res_ready  input  1  downstream accepts result.
REQ-018 frame_count  output  16  frames completed, wraps 0xFFFF->0x0000.
REQ-019 err_len  output  1  one-cycle pulse on short frame.

Function
REQ-020 FSM SHALL have states FILL, START, WAIT, RESULT.
REQ-021 s_ready SHALL equal (state==FILL) and be 0 while rst is high.
REQ-022 Transfer SHALL occur only when s_valid && s_ready; sample written to element idx, idx incremented.
REQ-023 Transfer at idx==N_ELEM-1 SHALL move FILL->START; s_last on that transfer optional, no effect.
REQ-024 Transfer with s_last at idx<N_ELEM-1 SHALL write the sample, pulse err_len next cycle, reset idx to 0, stay FILL; buffer contents not cleared; no disc_start.
REQ-025 START SHALL drive disc_start=1 for exactly one cycle, then go to WAIT; disc_start goes high the cycle after the final transfer.
REQ-026 flat_input SHALL remain stable from START until leaving RESULT.
REQ-027 Loader SHALL register disc_done into done_q; WAIT SHALL complete only on rising edge (disc_done && !done_q), so a done level left over from the previous frame is not accepted.
REQ-028 On that edge, disc_score/disc_decision SHALL be captured into res_score/res_decision, res_valid set next cycle, state->RESULT.
REQ-029 disc_done edges outside WAIT SHALL be ignored.
REQ-030 RESULT SHALL hold res_valid, res_score, res_decision stable until res_ready is sampled high.
REQ-031 On res_valid && res_ready: res_valid cleared, frame_count incremented, idx=0, state->FILL; s_ready high the following cycle.
REQ-032 No timeout; WAIT persists indefinitely without disc_done.
REQ-033 No arithmetic on samples; data passes bit-exact.

Reset
REQ-034 On rst: state=FILL, idx=0, all buffer elements 0 (flat_input=0), disc_start=0, res_valid=0, res_score=0, res_decision=0, frame_count=0, err_len=0, done_q=0.
REQ-035 Reset asserted in any state, including mid-WAIT, SHALL abort the frame; a disc_done arriving after release while in FILL is ignored.

Verification
REQ-036 Ramp frame s_data=k for k=0..255, s_valid held high -> flat_input element k = k; disc_start single pulse exactly one cycle after 256th transfer.
REQ-037 s_valid held high during START/WAIT/RESULT -> s_ready=0, no buffer change, flat_input unchanged.
REQ-038 Stub raises disc_done 10 cycles after disc_start with disc_score=0x0180, disc_decision=1 -> res_valid=1, res_score=0x0180, res_decision=1; held with res_ready=0 for 5 cycles; after res_ready, frame_count=1.
REQ-039 s_last on 100th sample (idx 99) -> err_len one-cycle pulse, no disc_start; following full 256-sample frame processed normally.
REQ-040 disc_done held high continuously from frame 1 into frame 2 -> no capture in frame 2 until disc_done drops and rises again.
REQ-041 rst pulsed mid-WAIT -> all outputs zero per REQ-034, s_ready=1 after release, subsequent disc_done produces no res_valid.
